multichannel_accumulator: RTL and testbench
===========================================

MULTICHANNEL_ACCUMULATOR -- requirements
Module: multichannel_accumulator

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the signed input sample width.
REQ-002 The block SHALL have parameter ACC_W, default 24, giving the signed accumulator width, with ACC_W >= DATA_W.
REQ-003 The block SHALL have parameter NUM_CH, default 4, giving the number of independent channels, with CH_W = max(1, clog2(NUM_CH)).
REQ-004 The block SHALL have parameter CNT_W, default 8, giving the per-channel sample-counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: an operation is offered.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-009 The block SHALL have port in_ch, input, CH_W bits: the target channel.
REQ-010 The block SHALL have port in_op, input, 2 bits, encoded 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
REQ-011 The block SHALL have port in_data, input, DATA_W bits: a signed operand.
REQ-012 The block SHALL have port clear_all, input, 1 bit: a request to sweep-clear all channels.
REQ-013 The block SHALL have ports out_valid (1 bit), out_ch (CH_W bits), out_acc (ACC_W bits), out_count (CNT_W bits) and out_ovf (1 bit), all outputs, giving the registered post-update result.

Function
REQ-014 A transfer SHALL occur exactly on a rising clk edge where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be driven combinationally as (state == IDLE) and (clear_all == 0).
REQ-016 The data operations on a transfer SHALL be: ADD sets acc to acc + sext(in_data); SUB sets acc to acc - sext(in_data); LOAD sets acc to sext(in_data); CLEAR sets acc to 0.
REQ-017 The count operations on a transfer SHALL be: ADD and SUB increment count, saturating at all-ones; LOAD sets count to 1; CLEAR sets count to 0.
REQ-018 The flag operations on a transfer SHALL be: LOAD and CLEAR clear the channel's sticky ovf; ADD and SUB set sticky ovf on signed overflow of the ACC_W result.
REQ-019 The accepted channel's state SHALL update on the accepting edge, so back-to-back transfers to the same channel see the updated value with no bubble and no hazard.
REQ-020 On the edge after a transfer (latency 1), out_valid SHALL be 1 and out_ch, out_acc, out_count and out_ovf SHALL show the new channel state; otherwise out_valid SHALL be 0 and the other outputs SHALL hold their previous values.
REQ-021 A transfer with in_ch >= NUM_CH SHALL be accepted and discarded: no state change and out_valid 0.
REQ-022 The FSM SHALL have two states, IDLE and SWEEP: in IDLE, clear_all=1 moves to SWEEP with sweep index 0.
REQ-023 In SWEEP, each cycle SHALL zero the acc, count and ovf of the indexed channel and increment the index.
REQ-024 After NUM_CH cycles, SWEEP SHALL return to IDLE.
REQ-025 clear_all asserted during SWEEP SHALL be ignored, and no out_valid SHALL be generated by the sweep.
REQ-026 If clear_all and in_valid are both 1 in IDLE, clear_all SHALL win and the operation SHALL not be accepted (in_ready=0).

Reset
REQ-027 When reset=1, all channel acc, count and ovf values SHALL be 0 and state SHALL be IDLE.
REQ-028 When reset=1, out_valid, out_ch, out_acc, out_count and out_ovf SHALL all be 0.
REQ-029 Reset asserted mid-SWEEP or mid-stream SHALL abort immediately, with no pending out_valid after release.

Configuration
REQ-030 When macro MULTICHANNEL_ACCUMULATOR_SATURATE_EN is defined, an overflowing ADD or SUB SHALL clamp acc to the signed ACC_W maximum or minimum and set sticky ovf.
REQ-031 When MULTICHANNEL_ACCUMULATOR_SATURATE_EN is undefined, acc SHALL wrap modulo 2^ACC_W and sticky ovf SHALL still be set.

Structure
REQ-032 Package acc_pkg SHALL hold the op encoding constants (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR) and the FSM state constants.
REQ-033 Sub-module acc_channel_alu SHALL be combinational: acc, count, op and data in; next acc, next count and overflow out, with saturation or wrap selected by the macro.
REQ-034 The top level SHALL own the register file, FSM, handshake and output register.

Verification
REQ-035 Directed test: after reset, ADD 5 then ADD 3 on ch2 -> out_valid on 2 consecutive cycles, out_acc 5 then 8, out_count 1 then 2, out_ovf 0.
REQ-036 Directed test: LOAD 0x7FFF on ch1 then 256 ADDs of 0x7FFF -> SATURATE_EN gives out_acc 0x7FFFFF, ovf 1; without it the wrapped value, ovf 1; count stays 0xFF.
REQ-037 Directed test: SUB 10 on ch0 from 0 -> out_acc 0xFFFFF6, count 1; then CLEAR -> out_acc 0, count 0, ovf 0.
REQ-038 Directed test: clear_all with in_valid in the same cycle -> in_ready 0 for exactly NUM_CH+1 cycles, no out_valid, all channels 0 on readback via ADD 0.
REQ-039 Directed test: reset pulsed during cycle 2 of SWEEP -> state IDLE, in_ready 1 after release, all outputs 0.
REQ-040 Directed test: in_ch = NUM_CH with NUM_CH=3 -> transfer accepted, out_valid 0, no channel changed.

Source files
------------

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for multichannel_accumulator.
// Holds the operation encodings carried on in_op and the FSM state type.
// Build option: MULTICHANNEL_ACCUMULATOR_SATURATE_EN (used by acc_channel_alu).
package acc_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/acc_channel_alu.sv
// acc_channel_alu: combinational next-state computation for one channel.
// Ports:
//   acc, count       current channel accumulator and sample count
//   op, data         operation code and signed operand
//   acc_next         accumulator after the operation
//   count_next       sample count after the operation
//   ovf              signed overflow of an ADD/SUB result
// Build option: MULTICHANNEL_ACCUMULATOR_SATURATE_EN clamps overflowing results
// to the signed range; without it the result wraps modulo 2^ACC_W.
module acc_channel_alu
    import acc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [CNT_W-1:0]  count,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] data,
    output logic [ACC_W-1:0]  acc_next,
    output logic [CNT_W-1:0]  count_next,
    output logic              ovf
);

    logic              arith;
    logic [ACC_W:0]    acc_x;
    logic [ACC_W:0]    data_x;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  arith_res;

    assign arith  = (op == OP_ADD) || (op == OP_SUB);
    assign acc_x  = (ACC_W+1)'($signed(acc));
    assign data_x = (ACC_W+1)'($signed(data));
    assign sum    = (op == OP_SUB) ? acc_x - data_x : acc_x + data_x;
    // One guard bit: the top two bits disagree exactly when the result left the ACC_W range.
    assign ovf    = arith && (sum[ACC_W] != sum[ACC_W-1]);

`ifdef MULTICHANNEL_ACCUMULATOR_SATURATE_EN
    logic [ACC_W-1:0] clamp;
    assign clamp     = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    assign arith_res = ovf ? clamp : sum[ACC_W-1:0];
`else
    assign arith_res = sum[ACC_W-1:0];
`endif

    always_comb begin
        acc_next   = arith ? arith_res : (op == OP_LOAD) ? ACC_W'($signed(data)) : '0;
        count_next = arith ? ((&count) ? count : count + CNT_W'(1))
                           : (op == OP_LOAD) ? CNT_W'(1) : '0;
    end

endmodule

// File: rtl/multichannel_accumulator.sv
// multichannel_accumulator: NUM_CH independent signed accumulators with counts
// and sticky overflow flags, a valid/ready operation port and a sweep-clear.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready operation handshake; in_ready is low while sweeping or
//                     while clear_all is requested
//   in_ch, in_op,     target channel, operation (ADD/SUB/LOAD/CLEAR), operand
//   in_data
//   clear_all         starts a one-channel-per-cycle clear of every channel
//   out_valid, out_ch, out_acc, out_count, out_ovf
//                     registered channel state one cycle after a transfer
// Build option: MULTICHANNEL_ACCUMULATOR_SATURATE_EN (see acc_channel_alu).
module multichannel_accumulator
    import acc_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int ACC_W  = 24,
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear_all,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t            state;
    state_t            state_next;
    logic [CH_W-1:0]   sweep_idx;
    logic              sweep_last;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] ovf_q;
    logic              fire;
    logic              ch_ok;
    logic [ACC_W-1:0]  acc_cur;
    logic [CNT_W-1:0]  cnt_cur;
    logic              ovf_cur;
    logic [ACC_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              alu_ovf;
    logic              ovf_next;

    assign in_ready   = (state == IDLE) && !clear_all;
    assign fire       = in_valid && in_ready;
    // Out-of-range channels are still accepted, just never written or reported.
    assign ch_ok      = int'(in_ch) < NUM_CH;
    assign sweep_last = int'(sweep_idx) == NUM_CH - 1;
    assign acc_cur    = ch_ok ? acc_q[in_ch] : '0;
    assign cnt_cur    = ch_ok ? cnt_q[in_ch] : '0;
    assign ovf_cur    = ch_ok ? ovf_q[in_ch] : 1'b0;
    assign ovf_next   = (in_op == OP_ADD || in_op == OP_SUB) ? (ovf_cur | alu_ovf) : 1'b0;

    acc_channel_alu #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) u_alu (
        .acc        (acc_cur),
        .count      (cnt_cur),
        .op         (in_op),
        .data       (in_data),
        .acc_next   (acc_next),
        .count_next (cnt_next),
        .ovf        (alu_ovf)
    );

    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = clear_all ? SWEEP : IDLE;
        else
            state_next = sweep_last ? IDLE : SWEEP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ovf_q     <= '0;
            sweep_idx <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == SWEEP) begin
                acc_q[sweep_idx] <= '0;
                cnt_q[sweep_idx] <= '0;
                ovf_q[sweep_idx] <= 1'b0;
                sweep_idx        <= sweep_idx + CH_W'(1);
            end else begin
                sweep_idx <= '0;
                if (fire && ch_ok) begin
                    acc_q[in_ch] <= acc_next;
                    cnt_q[in_ch] <= cnt_next;
                    ovf_q[in_ch] <= ovf_next;
                    out_valid    <= 1'b1;
                    out_ch       <= in_ch;
                    out_acc      <= acc_next;
                    out_count    <= cnt_next;
                    out_ovf      <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_multichannel_accumulator.sv
// tb_multichannel_accumulator: self-checking bench for multichannel_accumulator
// (default 4-channel instance plus a 3-channel instance for range checks).
module tb_multichannel_accumulator;

    localparam int     DATA_W = 16;
    localparam int     ACC_W  = 24;
    localparam int     NUM_CH = 4;
    localparam int     CNT_W  = 8;
    localparam longint MAXV   = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MINV   = -(longint'(1) << (ACC_W - 1));
    localparam longint MODV   = longint'(1) << ACC_W;
    localparam int     CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_ch = '0;
    logic [1:0]        in_op = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              clear_all = 1'b0;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    logic              b_valid = 1'b0;
    logic              b_ready;
    logic [1:0]        b_ch = '0;
    logic [1:0]        b_op = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_clear = 1'b0;
    logic              b_out_valid;
    logic [1:0]        b_out_ch;
    logic [ACC_W-1:0]  b_out_acc;
    logic [CNT_W-1:0]  b_out_count;
    logic              b_out_ovf;

    int n_chk = 0;
    int n_err = 0;

    longint m_acc [NUM_CH];
    int     m_cnt [NUM_CH];
    bit     m_ovf [NUM_CH];
    int     l_ch;
    longint l_acc;
    int     l_cnt;
    bit     l_ovf;

    typedef struct {
        int     ch;
        int     op;
        int     data;
        longint acc;
        int     cnt;
        bit     ovf;
    } vec_t;
    vec_t tbl [6];

    multichannel_accumulator #(
        .DATA_W (DATA_W), .ACC_W (ACC_W), .NUM_CH (NUM_CH), .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_op     (in_op),
        .in_data   (in_data),
        .clear_all (clear_all),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    multichannel_accumulator #(
        .DATA_W (DATA_W), .ACC_W (ACC_W), .NUM_CH (3), .CNT_W (CNT_W)
    ) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .in_ch     (b_ch),
        .in_op     (b_op),
        .in_data   (b_data),
        .clear_all (b_clear),
        .out_valid (b_out_valid),
        .out_ch    (b_out_ch),
        .out_acc   (b_out_acc),
        .out_count (b_out_count),
        .out_ovf   (b_out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint mask(input longint v);
        return v & (MODV - 1);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
            m_ovf[i] = 0;
        end
    endtask

    // Reference: exact integer arithmetic, then range handling on the result.
    task automatic model_apply(input int ch, input int op, input logic [DATA_W-1:0] data);
        longint d;
        longint r;
        d = longint'($signed(data));
        if (op == 0 || op == 1) begin
            r = (op == 0) ? m_acc[ch] + d : m_acc[ch] - d;
            if (r > MAXV || r < MINV) begin
                m_ovf[ch] = 1;
`ifdef MULTICHANNEL_ACCUMULATOR_SATURATE_EN
                r = (r > MAXV) ? MAXV : MINV;
`else
                r = mask(r);
                if (r > MAXV) r = r - MODV;
`endif
            end
            m_acc[ch] = r;
            m_cnt[ch] = (m_cnt[ch] == CMAX) ? CMAX : m_cnt[ch] + 1;
        end else if (op == 2) begin
            m_acc[ch] = d;
            m_cnt[ch] = 1;
            m_ovf[ch] = 0;
        end else begin
            m_acc[ch] = 0;
            m_cnt[ch] = 0;
            m_ovf[ch] = 0;
        end
        l_ch  = ch;
        l_acc = m_acc[ch];
        l_cnt = m_cnt[ch];
        l_ovf = m_ovf[ch];
    endtask

    task automatic do_op(input int ch, input int op, input logic [DATA_W-1:0] data);
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        in_op    = 2'(op);
        in_data  = data;
        #1;
        check("in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_apply(ch, op, data);
        check("out_valid", 64'(out_valid), 64'(1));
        check("out_ch", 64'(out_ch), 64'(l_ch));
        check("out_acc", 64'(out_acc), 64'(mask(l_acc)));
        check("out_count", 64'(out_count), 64'(l_cnt));
        check("out_ovf", 64'(out_ovf), 64'(l_ovf));
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_valid", 64'(out_valid), 64'(0));
        check("idle_hold_acc", 64'(out_acc), 64'(mask(l_acc)));
        check("idle_hold_ch", 64'(out_ch), 64'(l_ch));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_ch"}, 64'(out_ch), 64'(0));
        check({tag, "_acc"}, 64'(out_acc), 64'(0));
        check({tag, "_count"}, 64'(out_count), 64'(0));
        check({tag, "_ovf"}, 64'(out_ovf), 64'(0));
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        int low;
        int r;
        logic [DATA_W-1:0] d;
        tbl[0] = '{2, 0, 5,          64'd5,        1, 1'b0};
        tbl[1] = '{2, 0, 3,          64'd8,        2, 1'b0};
        tbl[2] = '{0, 1, 10,         64'hFFFFF6,   1, 1'b0};
        tbl[3] = '{0, 3, 0,          64'd0,        0, 1'b0};
        tbl[4] = '{3, 2, 'h8000,     64'hFF8000,   1, 1'b0};
        tbl[5] = '{3, 1, 'h8000,     64'd0,        2, 1'b0};
        model_clear();
        l_ch = 0; l_acc = 0; l_cnt = 0; l_ovf = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("post_rst");

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].ch, tbl[i].op, DATA_W'(tbl[i].data));
            check("tbl_acc", 64'(out_acc), 64'(tbl[i].acc));
            check("tbl_count", 64'(out_count), 64'(tbl[i].cnt));
            check("tbl_ovf", 64'(out_ovf), 64'(tbl[i].ovf));
        end
        idle_cycle();

        // Positive overflow, then negative overflow, on ch1.
        do_op(1, 2, 16'h7FFF);
        repeat (256) do_op(1, 0, 16'h7FFF);
`ifdef MULTICHANNEL_ACCUMULATOR_SATURATE_EN
        check("pos_ovf_acc", 64'(out_acc), 64'h7FFFFF);
`else
        check("pos_ovf_acc", 64'(out_acc), 64'h807EFF);
`endif
        check("pos_ovf_flag", 64'(out_ovf), 64'(1));
        check("pos_ovf_count", 64'(out_count), 64'hFF);
        do_op(1, 2, 16'h8000);
        check("load_clears_ovf", 64'(out_ovf), 64'(0));
        repeat (256) do_op(1, 0, 16'h8000);
`ifdef MULTICHANNEL_ACCUMULATOR_SATURATE_EN
        check("neg_ovf_acc", 64'(out_acc), 64'h800000);
`else
        check("neg_ovf_acc", 64'(out_acc), 64'h7F8000);
`endif
        check("neg_ovf_flag", 64'(out_ovf), 64'(1));

        // Randomized mix against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle();
            end else begin
                r = $urandom_range(0, 9);
                d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000)
                                                : DATA_W'($urandom);
                do_op($urandom_range(0, 3), (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3, d);
            end
        end

        // clear_all together with an offered operation.
        do_op(0, 2, 16'd123);
        in_valid  = 1'b1;
        in_ch     = 2'd0;
        in_op     = 2'd0;
        in_data   = 16'd1;
        clear_all = 1'b1;
        #1;
        low = (in_ready == 1'b0) ? 1 : 0;
        @(posedge clk);
        #1;
        clear_all = 1'b0;
        in_valid  = 1'b0;
        check("sweep_no_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 20; i++) begin
            if (in_ready) break;
            low++;
            @(posedge clk);
            #1;
            check("sweep_no_valid", 64'(out_valid), 64'(0));
        end
        check("ready_low_cycles", 64'(low), 64'(NUM_CH + 1));
        model_clear();
        for (int c = 0; c < NUM_CH; c++) begin
            do_op(c, 0, 16'd0);
            check("sweep_readback_acc", 64'(out_acc), 64'(0));
            check("sweep_readback_cnt", 64'(out_count), 64'(1));
        end

        // Reset during the second sweep cycle.
        do_op(2, 2, 16'd77);
        clear_all = 1'b1;
        @(posedge clk);
        #1;
        clear_all = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_sweep_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("after_sweep_rst");
        model_clear();
        l_ch = 0; l_acc = 0; l_cnt = 0; l_ovf = 0;
        do_op(2, 0, 16'd0);
        check("rst_readback_acc", 64'(out_acc), 64'(0));

        // Out-of-range channel on the 3-channel instance.
        b_valid = 1'b1;
        b_ch    = 2'd2;
        b_op    = 2'd2;
        b_data  = 16'd9;
        #1;
        check("b_ready", 64'(b_ready), 64'(1));
        @(posedge clk);
        #1;
        check("b_load_valid", 64'(b_out_valid), 64'(1));
        check("b_load_acc", 64'(b_out_acc), 64'(9));
        b_ch   = 2'd3;
        b_op   = 2'd0;
        b_data = 16'd7;
        #1;
        check("b_oor_ready", 64'(b_ready), 64'(1));
        @(posedge clk);
        #1;
        check("b_oor_valid", 64'(b_out_valid), 64'(0));
        check("b_oor_hold_acc", 64'(b_out_acc), 64'(9));
        check("b_oor_hold_ch", 64'(b_out_ch), 64'(2));
        for (int c = 0; c < 3; c++) begin
            b_ch   = 2'(c);
            b_op   = 2'd0;
            b_data = 16'd0;
            @(posedge clk);
            #1;
            check("b_rb_valid", 64'(b_out_valid), 64'(1));
            check("b_rb_acc", 64'(b_out_acc), (c == 2) ? 64'(9) : 64'(0));
            check("b_rb_cnt", 64'(b_out_count), (c == 2) ? 64'(2) : 64'(1));
            check("b_rb_ovf", 64'(b_out_ovf), 64'(0));
        end
        b_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
